fader_accum: RTL and testbench

- Downstream stage of the fading generator. Consumes the per-reflector cosine ROM samples (real and imaginary) for each channel.
- Sums the M reflector terms of each channel into one complex fading coefficient and emits one output word per channel.
- Checks the reflector/channel sequencing of the upstream stream and flags violations.

---
 rtl/fader_accum_pkg.sv | 28 ++
 rtl/fader_accum_sat_shift.sv | 33 +++
 rtl/fader_accum.sv | 139 +++++++++++++
 tb/tb_fader_accum.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fader_accum_pkg.sv
// rtl/fader_accum_pkg.sv - shared types and constants for the fading coefficient accumulator
package fader_accum_pkg;

   localparam int FADER_M         = 8;
   localparam int FADER_N         = 32;
   localparam int FADER_WPATH     = 3;
   localparam int FADER_WCHAN     = 5;
   localparam int FADER_WIN       = 12;
   localparam int FADER_OUT_SHIFT = 1;
   localparam int FADER_OUT_W     = 16;

   // Accumulator width: M samples of Win bits never overflow Win+Wpath bits
   localparam int FADER_ACC_W = FADER_WIN + FADER_WPATH;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } fader_state_t;

   // One upstream ROM sample as seen on the in_* bus
   typedef struct packed {
      logic        [FADER_WPATH-1:0] m;
      logic        [FADER_WCHAN-1:0] chan;
      logic signed [FADER_WIN-1:0]   samp_real;
      logic signed [FADER_WIN-1:0]   samp_imag;
   } fader_sample_t;

endpackage

// File: rtl/fader_accum_sat_shift.sv
// rtl/fader_accum_sat_shift.sv - sign-extend, left shift and saturate a signed sum
module sat_shift #(
   parameter int IN_W  = 15,
   parameter int OUT_W = 16,
   parameter int SHIFT = 1
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);

   // Wide enough that a shift of up to 4 on a 16-bit extended value cannot wrap
   localparam int WIDE = OUT_W + 5;

   localparam logic signed [WIDE-1:0] MAXV = WIDE'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [WIDE-1:0] MINV = WIDE'(-(64'sd1 <<< (OUT_W - 1)));

   logic signed [WIDE-1:0] wide;
   logic signed [WIDE-1:0] shifted;

   // Extend, shift, then clamp to the representable output range
   always_comb begin
      wide    = {{(WIDE - IN_W){din[IN_W-1]}}, din};
      shifted = wide <<< SHIFT;
      if (shifted > MAXV) begin
         dout = {1'b0, {(OUT_W - 1){1'b1}}};
      end else if (shifted < MINV) begin
         dout = {1'b1, {(OUT_W - 1){1'b0}}};
      end else begin
         dout = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/fader_accum.sv
// rtl/fader_accum.sv - sums M reflector samples per channel into one complex fading coefficient
module fader_accum
   import fader_accum_pkg::*;
#(
   parameter int M         = FADER_M,
   parameter int N         = FADER_N,
   parameter int Wpath     = FADER_WPATH,
   parameter int Wchan     = FADER_WCHAN,
   parameter int Win       = FADER_WIN,
   parameter int OUT_SHIFT = FADER_OUT_SHIFT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [Wpath-1:0]        in_m,
   input  logic [Wchan-1:0]        in_chan,
   input  logic signed [Win-1:0]   in_real,
   input  logic signed [Win-1:0]   in_imag,
   output logic                    dv_out,
   output logic [Wchan-1:0]        chan_out,
   output logic signed [15:0]      Zc_real,
   output logic signed [15:0]      Zc_imag,
   output logic                    frame_done,
   output logic                    seq_err
);

   localparam int ACC_W = Win + Wpath;
   localparam logic [Wpath-1:0] M_LAST = Wpath'(M - 1);

   fader_sample_t smp;
   fader_state_t  state, state_nxt;

   logic signed [ACC_W-1:0] acc_real, acc_imag;
   logic signed [ACC_W-1:0] ext_real, ext_imag;
   logic signed [ACC_W-1:0] sum_real, sum_imag;
   logic signed [15:0]      sat_real, sat_imag;
   logic [Wpath-1:0]        exp_m;
   logic [$clog2(N)-1:0]    lat_chan;

   logic acc_ld, acc_add, err, emit;

   assign smp = '{m: in_m, chan: in_chan, samp_real: in_real, samp_imag: in_imag};

   // Sign-extend the incoming sample and form the running sum including it
   always_comb begin
      ext_real = {{Wpath{smp.samp_real[Win-1]}}, smp.samp_real};
      ext_imag = {{Wpath{smp.samp_imag[Win-1]}}, smp.samp_imag};
      sum_real = acc_real + ext_real;
      sum_imag = acc_imag + ext_imag;
   end

   sat_shift #(.IN_W(ACC_W), .OUT_W(16), .SHIFT(OUT_SHIFT)) u_sat_real (
      .din  (sum_real),
      .dout (sat_real)
   );

   sat_shift #(.IN_W(ACC_W), .OUT_W(16), .SHIFT(OUT_SHIFT)) u_sat_imag (
      .din  (sum_imag),
      .dout (sat_imag)
   );

   // Sequencing FSM: decide whether each valid sample starts, extends, restarts or breaks a group
   always_comb begin
      state_nxt = state;
      acc_ld    = 1'b0;
      acc_add   = 1'b0;
      err       = 1'b0;
      emit      = 1'b0;
      if (in_valid) begin
         case (state)
            ST_IDLE: begin
               if (smp.m == M_LAST) begin
                  acc_ld    = 1'b1;
                  state_nxt = ST_ACCUM;
               end else begin
                  err = 1'b1;
               end
            end
            ST_ACCUM: begin
               if (smp.m == exp_m && smp.chan == lat_chan) begin
                  acc_add = 1'b1;
                  if (smp.m == '0) begin
                     emit      = 1'b1;
                     state_nxt = ST_IDLE;
                  end
               end else if (smp.m == M_LAST) begin
                  // A new group started early: drop the partial sum and restart on this sample
                  err    = 1'b1;
                  acc_ld = 1'b1;
               end else begin
                  err       = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, accumulators, error flag and registered output word
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         acc_real   <= '0;
         acc_imag   <= '0;
         exp_m      <= '0;
         lat_chan   <= '0;
         seq_err    <= 1'b0;
         dv_out     <= 1'b0;
         frame_done <= 1'b0;
         chan_out   <= '0;
         Zc_real    <= '0;
         Zc_imag    <= '0;
      end else begin
         state <= state_nxt;
         if (acc_ld) begin
            acc_real <= ext_real;
            acc_imag <= ext_imag;
            exp_m    <= M_LAST - Wpath'(1);
            lat_chan <= smp.chan;
         end else if (acc_add) begin
            acc_real <= sum_real;
            acc_imag <= sum_imag;
            exp_m    <= exp_m - Wpath'(1);
         end
         if (err) begin
            seq_err <= 1'b1;
         end
         dv_out     <= emit;
         frame_done <= emit && (lat_chan == '0);
         if (emit) begin
            chan_out <= lat_chan;
            Zc_real  <= sat_real;
            Zc_imag  <= sat_imag;
         end
      end
   end

endmodule

// File: tb/tb_fader_accum.sv
// tb/tb_fader_accum.sv - scoreboard bench for fader_accum
module tb_fader_accum;

   localparam int M = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic [2:0]         in_m;
   logic [4:0]         in_chan;
   logic signed [11:0] in_real;
   logic signed [11:0] in_imag;

   logic               dv_out, frame_done, seq_err;
   logic [4:0]         chan_out;
   logic signed [15:0] Zc_real, Zc_imag;

   logic               dv4, fd4, se4;
   logic [4:0]         chan4;
   logic signed [15:0] zr4, zi4;

   int checks   = 0;
   int failures = 0;
   int dv_cnt   = 0;
   int fd_cnt   = 0;

   typedef struct {
      int chan;
      int re;
      int im;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];

   always #5 clk = ~clk;

   fader_accum #(.OUT_SHIFT(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_m(in_m), .in_chan(in_chan),
      .in_real(in_real), .in_imag(in_imag), .dv_out(dv_out), .chan_out(chan_out),
      .Zc_real(Zc_real), .Zc_imag(Zc_imag), .frame_done(frame_done), .seq_err(seq_err)
   );

   fader_accum #(.OUT_SHIFT(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_m(in_m), .in_chan(in_chan),
      .in_real(in_real), .in_imag(in_imag), .dv_out(dv4), .chan_out(chan4),
      .Zc_real(zr4), .Zc_imag(zi4), .frame_done(fd4), .seq_err(se4)
   );

   function automatic int sat16(input int s, input int sh);
      int v;
      v = s * (1 << sh);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Scoreboard for the OUT_SHIFT=1 instance
   always @(negedge clk) begin
      if (dv_out) begin
         dv_cnt++;
         checks++;
         if (q1.size() == 0) begin
            failures++;
            $display("FAIL sb1_unexpected dv_out chan=%0d", chan_out);
         end else begin
            exp_t e;
            e = q1.pop_front();
            if (chan_out !== e.chan[4:0] || Zc_real !== 16'(e.re) || Zc_imag !== 16'(e.im)
                || frame_done !== (e.chan == 0)) begin
               failures++;
               $display("FAIL sb1_word got chan=%0d re=%0d im=%0d fd=%0b want chan=%0d re=%0d im=%0d fd=%0b",
                        chan_out, Zc_real, Zc_imag, frame_done, e.chan, e.re, e.im, (e.chan == 0));
            end
         end
      end else if (frame_done) begin
         checks++;
         failures++;
         $display("FAIL sb1_frame_done got 1 without dv_out want 0");
      end
      if (frame_done) fd_cnt++;
   end

   // Scoreboard for the OUT_SHIFT=4 instance
   always @(negedge clk) begin
      if (dv4) begin
         checks++;
         if (q4.size() == 0) begin
            failures++;
            $display("FAIL sb4_unexpected dv_out chan=%0d", chan4);
         end else begin
            exp_t e;
            e = q4.pop_front();
            if (chan4 !== e.chan[4:0] || zr4 !== 16'(e.re) || zi4 !== 16'(e.im)) begin
               failures++;
               $display("FAIL sb4_word got chan=%0d re=%0d im=%0d want chan=%0d re=%0d im=%0d",
                        chan4, zr4, zi4, e.chan, e.re, e.im);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int m, input int chan, input int re, input int im);
      in_valid = 1'b1;
      in_m     = 3'(m);
      in_chan  = 5'(chan);
      in_real  = 12'(re);
      in_imag  = 12'(im);
      tick(1);
      in_valid = 1'b0;
   endtask

   // Clean group m=M-1..0; values fixed or random, optional random gaps; pushes expectations
   task automatic run_group(input int chan, input bit rnd, input int fre, input int fim,
                            input int gap_max);
      int sr, si, re, im;
      exp_t e;
      sr = 0;
      si = 0;
      for (int m = M - 1; m >= 0; m--) begin
         if (rnd) begin
            re = int'($urandom_range(4095)) - 2048;
            im = int'($urandom_range(4095)) - 2048;
         end else begin
            re = fre;
            im = fim;
         end
         sr += re;
         si += im;
         if (m == 0) begin
            e.chan = chan; e.re = sat16(sr, 1); e.im = sat16(si, 1);
            q1.push_back(e);
            e.re = sat16(sr, 4); e.im = sat16(si, 4);
            q4.push_back(e);
         end
         send(m, chan, re, im);
         if (gap_max > 0 && m != 0) tick(int'($urandom_range(gap_max)));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      checks++;
      if (dv_out !== 1'b0 || frame_done !== 1'b0 || seq_err !== 1'b0 || chan_out !== 5'd0
          || Zc_real !== 16'sd0 || Zc_imag !== 16'sd0) begin
         failures++;
         $display("FAIL reset_state got dv=%0b fd=%0b se=%0b ch=%0d re=%0d im=%0d want all 0",
                  dv_out, frame_done, seq_err, chan_out, Zc_real, Zc_imag);
      end
   endtask

   task automatic test_basic();
      int d0;
      d0 = dv_cnt;
      run_group(5, 1'b0, 100, -100, 0);
      checks++;
      if (dv_out !== 1'b1) begin
         failures++;
         $display("FAIL basic_latency got dv_out=%0b want 1", dv_out);
      end
      checks++;
      if (Zc_real !== 16'sd1600 || Zc_imag !== -16'sd1600 || chan_out !== 5'd5) begin
         failures++;
         $display("FAIL basic_value got re=%0d im=%0d ch=%0d want 1600 -1600 5", Zc_real, Zc_imag, chan_out);
      end
      tick(3);
      checks++;
      if (dv_cnt - d0 != 1 || seq_err !== 1'b0) begin
         failures++;
         $display("FAIL basic_count got dv=%0d se=%0b want 1 0", dv_cnt - d0, seq_err);
      end
   endtask

   task automatic test_saturation();
      run_group(4, 1'b0, 2047, -2048, 0);
      tick(2);
      checks++;
      if (zr4 !== 16'sd32767 || zi4 !== -16'sd32768) begin
         failures++;
         $display("FAIL sat_shift4 got re=%0d im=%0d want 32767 -32768", zr4, zi4);
      end
      checks++;
      if (Zc_real !== 16'sd32752 || Zc_imag !== -16'sd32768) begin
         failures++;
         $display("FAIL sat_shift1 got re=%0d im=%0d want 32752 -32768", Zc_real, Zc_imag);
      end
   endtask

   task automatic test_full_frame();
      int d0, f0;
      d0 = dv_cnt;
      f0 = fd_cnt;
      for (int c = 31; c >= 0; c--) begin
         run_group(c, 1'b1, 0, 0, 3);
         if ($urandom_range(1) == 1) tick(int'($urandom_range(4)));
      end
      tick(3);
      checks++;
      if (dv_cnt - d0 != 32 || fd_cnt - f0 != 1 || seq_err !== 1'b0) begin
         failures++;
         $display("FAIL frame_counts got dv=%0d fd=%0d se=%0b want 32 1 0",
                  dv_cnt - d0, fd_cnt - f0, seq_err);
      end
   endtask

   task automatic test_seq_error();
      int d0;
      d0 = dv_cnt;
      send(7, 3, 50, 50);
      send(6, 3, 50, 50);
      send(4, 3, 50, 50);
      tick(2);
      checks++;
      if (seq_err !== 1'b1 || dv_cnt != d0) begin
         failures++;
         $display("FAIL seqerr_flag got se=%0b dv=%0d want 1 0", seq_err, dv_cnt - d0);
      end
      run_group(2, 1'b1, 0, 0, 1);
      tick(2);
      checks++;
      if (seq_err !== 1'b1 || dv_cnt - d0 != 1) begin
         failures++;
         $display("FAIL seqerr_recover got se=%0b dv=%0d want 1 1", seq_err, dv_cnt - d0);
      end
   endtask

   task automatic test_early_restart();
      int d0;
      d0 = dv_cnt;
      send(7, 9, 10, 10);
      send(6, 9, 10, 10);
      send(5, 9, 10, 10);
      run_group(9, 1'b0, 10, 10, 0);
      tick(2);
      checks++;
      if (dv_cnt - d0 != 1 || Zc_real !== 16'(sat16(80, 1)) || seq_err !== 1'b1) begin
         failures++;
         $display("FAIL restart got dv=%0d re=%0d se=%0b want 1 %0d 1",
                  dv_cnt - d0, Zc_real, seq_err, sat16(80, 1));
      end
   endtask

   task automatic test_mid_reset();
      int d0;
      for (int m = 7; m >= 3; m--) send(m, 7, 300, -300);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checks++;
      if (dv_out !== 1'b0 || seq_err !== 1'b0 || chan_out !== 5'd0 || Zc_real !== 16'sd0
          || Zc_imag !== 16'sd0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL midreset_state got dv=%0b se=%0b ch=%0d re=%0d im=%0d want all 0",
                  dv_out, seq_err, chan_out, Zc_real, Zc_imag);
      end
      d0 = dv_cnt;
      for (int m = 2; m >= 0; m--) send(m, 7, 300, -300);
      tick(2);
      checks++;
      if (seq_err !== 1'b1 || dv_cnt != d0) begin
         failures++;
         $display("FAIL midreset_drop got se=%0b dv=%0d want 1 0", seq_err, dv_cnt - d0);
      end
      run_group(6, 1'b0, -7, 13, 2);
      tick(2);
      checks++;
      if (dv_cnt - d0 != 1 || Zc_real !== -16'sd112 || Zc_imag !== 16'sd208 || chan_out !== 5'd6) begin
         failures++;
         $display("FAIL midreset_next got dv=%0d re=%0d im=%0d ch=%0d want 1 -112 208 6",
                  dv_cnt - d0, Zc_real, Zc_imag, chan_out);
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_m     = '0;
      in_chan  = '0;
      in_real  = '0;
      in_imag  = '0;
      tick(1);
      test_reset();
      test_basic();
      test_saturation();
      test_full_frame();
      test_seq_error();
      test_early_restart();
      test_mid_reset();
      tick(3);
      checks++;
      if (q1.size() != 0 || q4.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got pending=%0d/%0d want 0/0", q1.size(), q4.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
